// File: rtl/wb_mem_ctrl_pkg.sv
// Shared encodings for the MEM->WB memory sequencer: write-back select codes,
// FSM state encoding and the latched bus command.
package wb_mem_ctrl_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_EXT  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;
  localparam logic [1:0] WB_DREM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  function automatic logic [31:0] wb_select(input logic [1:0]  wsel,
                                            input logic [31:0] load_data,
                                            input logic [31:0] result);
    return (wsel == WB_DREM) ? load_data : result;
  endfunction

endpackage

// File: rtl/wb_mem_ctrl_to_counter.sv
// Bus timeout counter: cleared when an access starts, counts BUSY cycles and
// flags the terminal count TIMEOUT-1. Saturates there so it can never wrap.
module wb_to_counter #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_reg;
  logic [TO_W-1:0] cnt_next;

  assign tc = (cnt_reg == TC_VAL);

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en && !tc) begin
      cnt_next = cnt_reg + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/wb_mem_ctrl.sv
// MEM->WB sequencer: issues one bus access per load/store with a req/ack
// handshake, stalls the pipeline meanwhile, and registers the write-back word.
module wb_mem_ctrl
  import wb_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        mem_valid,
  input  logic [1:0]  mem_rf_wsel,
  input  logic        mem_rf_we,
  input  logic        mem_wr,
  input  logic [4:0]  mem_wR,
  input  logic [31:0] mem_wd_in,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_rf_we,
  output logic [4:0]  wb_wR,
  output logic [31:0] wb_wD,
  output logic        bus_err
);

  state_e      state_reg;
  state_e      state_next;
  bus_cmd_t    cmd_reg;
  bus_cmd_t    cmd_next;
  logic [31:0] load_q_reg;
  logic [31:0] load_q_next;
  logic        abort_reg;
  logic        abort_next;

  logic        wb_valid_reg;
  logic        wb_valid_next;
  logic        wb_rf_we_reg;
  logic        wb_rf_we_next;
  logic [4:0]  wb_wR_reg;
  logic [4:0]  wb_wR_next;
  logic [31:0] wb_wD_reg;
  logic [31:0] wb_wD_next;

  logic        is_load;
  logic        is_store;
  logic        to_clr;
  logic        to_en;
  logic        to_tc;

  // A load wins over a store when both decode true.
  assign is_load  = mem_valid & (mem_rf_wsel == WB_DREM);
  assign is_store = mem_valid & mem_wr & ~is_load;

  wb_to_counter #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_to_counter (
    .clk   (cpu_clk),
    .rst_n (cpu_rst_n),
    .clr   (to_clr),
    .en    (to_en),
    .tc    (to_tc)
  );

  always_comb begin
    state_next  = state_reg;
    cmd_next    = cmd_reg;
    load_q_next = load_q_reg;
    abort_next  = abort_reg;
    to_clr      = 1'b0;
    to_en       = 1'b0;
    stall       = 1'b0;
    bus_req     = 1'b0;
    bus_err     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (is_load || is_store) begin
          cmd_next   = '{we: is_store, addr: mem_addr, wdata: mem_wdata};
          abort_next = 1'b0;
          to_clr     = 1'b1;
          stall      = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        to_en   = 1'b1;
        // An ack on the terminal-count cycle still completes the access.
        if (bus_ack) begin
          load_q_next = bus_rdata;
          state_next  = ST_RESP;
        end else if (to_tc) begin
          load_q_next = '0;
          abort_next  = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        // The instruction is still presented here; it retires instead of re-issuing.
        bus_err    = abort_reg;
        abort_next = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wb_valid_next = 1'b0;
    wb_rf_we_next = 1'b0;
    wb_wR_next    = wb_wR_reg;
    wb_wD_next    = wb_wD_reg;
    if (!stall) begin
      wb_valid_next = mem_valid;
      wb_rf_we_next = mem_valid & mem_rf_we & ~mem_wr & ~abort_reg;
      wb_wR_next    = mem_wR;
      wb_wD_next    = wb_select(mem_rf_wsel, load_q_reg, mem_wd_in);
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      load_q_reg   <= '0;
      abort_reg    <= 1'b0;
      wb_valid_reg <= 1'b0;
      wb_rf_we_reg <= 1'b0;
      wb_wR_reg    <= '0;
      wb_wD_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      load_q_reg   <= load_q_next;
      abort_reg    <= abort_next;
      wb_valid_reg <= wb_valid_next;
      wb_rf_we_reg <= wb_rf_we_next;
      wb_wR_reg    <= wb_wR_next;
      wb_wD_reg    <= wb_wD_next;
    end
  end

  assign bus_we    = cmd_reg.we;
  assign bus_addr  = cmd_reg.addr;
  assign bus_wdata = cmd_reg.wdata;
  assign wb_valid  = wb_valid_reg;
  assign wb_rf_we  = wb_rf_we_reg;
  assign wb_wR     = wb_wR_reg;
  assign wb_wD     = wb_wD_reg;

endmodule

// File: doc/wb_mem_ctrl.md
Name: wb_mem_ctrl

Overview:
Sequencer for the MEM→WB boundary of the pipelined core. It issues data-memory loads and stores to a variable-latency bus using a req/ack handshake, and stalls the pipeline while an access is outstanding. It then forms the registered write-back word, choosing between the MEM-stage result and the returned load data according to rf_wsel, and drives the register-file write port. A timeout guards against a bus that never acknowledges.

Parameters:
TIMEOUT, 15, maximum number of BUSY cycles spent waiting for bus_ack before the access is aborted (legal range 1..255)
TO_W, 8, width of the timeout counter

Ports:
cpu_clk  in  1  core clock; all state updates on rising edge
cpu_rst_n  in  1  asynchronous, active-low reset
mem_valid  in  1  MEM-stage slot holds a valid instruction
mem_rf_wsel  in  2  write-back select; uses the `WB_ALU/`WB_EXT/`WB_PC/`WB_DREM codes
mem_rf_we  in  1  instruction writes the register file
mem_wr  in  1  instruction is a store
mem_wR  in  5  destination register index
mem_wd_in  in  32  non-load result (ALU, extended immediate or PC+4)
mem_addr  in  32  data-memory address
mem_wdata  in  32  store data
bus_req  out  1  access request
bus_we  out  1  1 = write, 0 = read
bus_addr  out  32  access address
bus_wdata  out  32  write data
bus_ack  in  1  access complete; bus_rdata is valid in the same cycle
bus_rdata  in  32  read data
stall  out  1  freezes IF/ID/EX/MEM and causes a bubble to be inserted into WB
wb_valid  out  1  WB slot valid
wb_rf_we  out  1  register-file write enable
wb_wR  out  5  register-file write index
wb_wD  out  32  register-file write data
bus_err  out  1  one-cycle pulse when an access has timed out

Behaviour:
- Decode: is_load = mem_valid & (mem_rf_wsel == `WB_DREM). is_store = mem_valid & mem_wr & ~is_load. If both decode true, the load takes priority.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If is_load or is_store: latch bus_addr, bus_wdata and bus_we (bus_we = is_store). Go to BUSY, with bus_req = 1 from the next cycle. Clear the timeout counter.
  - Otherwise: remain in IDLE.
- BUSY:
  - bus_req = 1; bus_addr, bus_wdata and bus_we are held stable.
  - On bus_ack: capture bus_rdata into load_q, drop bus_req, go to RESP.
  - If the counter reaches TIMEOUT - 1 without ack: set load_q = 0, set the abort flag, drop bus_req, go to RESP.
- RESP: one cycle, then go to IDLE. No new request is issued in RESP, even though the same MEM instruction is still presented.
- stall (combinational) = (IDLE & (is_load | is_store)) | BUSY. stall = 0 in RESP.
- Latency:
  - Non-memory instruction: no stall.
  - Access acked k cycles after bus_req rises (k ≥ 0): stall is high for k + 2 cycles.
  - Back-to-back memory instructions each pay the full cost; there is no pipelining of bus requests.
- WB register (updated every edge):
  - If stall = 1: wb_valid = 0 and wb_rf_we = 0; wb_wR and wb_wD hold.
  - Else: wb_valid = mem_valid and wb_wR = mem_wR.
  - wb_wD = load_q when mem_rf_wsel == `WB_DREM, otherwise mem_wd_in.
  - wb_rf_we = mem_valid & mem_rf_we & ~mem_wr & ~abort.
- bus_err = 1 in the RESP cycle of an aborted access only.
- A bus_ack seen in IDLE or RESP is ignored.
- Reset, which may be asserted mid-access: asynchronously go to IDLE. All outputs and internal registers go to 0 (bus_req, stall from state, wb_*, bus_err). No write-back of the interrupted access occurs after reset.

Decomposition:
- The `WB_ALU/`WB_EXT/`WB_PC/`WB_DREM codes and the FSM state encodings (2-bit) belong in the shared defines header.
- One natural sub-module: wb_to_counter, the timeout counter with clear, enable and terminal-count outputs.
- The FSM, bus-side latches and WB register stay in the top module.

Test Plan:
- Reset, then a non-memory ALU instruction: mem_valid=1, wsel=`WB_ALU, wd_in=0x1234, wR=5, rf_we=1 -> stall never asserts; next cycle wb_wD=0x1234, wb_wR=5, wb_rf_we=1.
- Load, addr=0x100, bus acks 2 cycles after bus_req rises with rdata=0xCAFEF00D -> stall high for 4 cycles; bus_addr is stable throughout; the cycle after RESP shows wb_wD=0xCAFEF00D and wb_rf_we=1; wb_valid=0 during stall.
- Store, addr=0x200, wdata=0xA5A5A5A5, ack=0 cycles -> bus_we=1 for one bus_req cycle; stall high for 2 cycles; wb_rf_we=0.
- Load with no ack, TIMEOUT=15 -> bus_req high for exactly 15 cycles; bus_err pulses once; wb_rf_we=0; a late bus_ack is ignored.
- Two loads back-to-back, both acked immediately -> exactly two bus_req pulses with the correct addresses; both write-backs occur in order; no duplicate request is issued in RESP.
- cpu_rst_n asserted during BUSY -> bus_req and stall drop immediately; after release, the FSM is in IDLE and wb_valid=0.
